// File: rtl/tetris_sequencer.sv
// tetris_sequencer: game-flow sequencer that sits in front of a Tetris core.
// All state advances once per frame on the rising edge of vsync.
//
// Ports
//   vsync        in   frame clock
//   Reset        in   asynchronous, active-high reset
//   keycodes     in   four 8-bit HID key codes, one per byte lane
//   score        in   core score, drives level progression
//   game_over    in   core lock-out flag
//   piece_req    in   one-frame pulse, the core consumed next_shape
//   core_reset   out  holds the core in reset in IDLE and START
//   keycodes_out out  key codes forwarded to the core, only in PLAY
//   grav_tick    out  one-frame gravity pulse
//   level        out  current level
//   state        out  FSM state (IDLE=0 START=1 PLAY=2 PAUSE=3 OVER=4)
//   next_shape   out  7-bag shape index 0..6
module tetris_sequencer #(
    parameter int unsigned BASE_DIV  = 48,
    parameter int unsigned DIV_STEP  = 4,
    parameter int unsigned MIN_DIV   = 4,
    parameter int unsigned LEVEL_PTS = 10,
    parameter int unsigned MAX_LEVEL = 15
) (
    input  logic        vsync,
    input  logic        Reset,
    input  logic [31:0] keycodes,
    input  logic [15:0] score,
    input  logic        game_over,
    input  logic        piece_req,
    output logic        core_reset,
    output logic [31:0] keycodes_out,
    output logic        grav_tick,
    output logic [3:0]  level,
    output logic [2:0]  state,
    output logic [2:0]  next_shape
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        enter_q, p_q, esc_q;
    logic [15:0] div_ctr_q, div_ctr_d;
    logic [3:0]  level_q, level_d;
    logic [15:0] thr_q, thr_d;
    logic [15:0] lfsr_q;
    logic [6:0]  used_q, used_d;
    logic [2:0]  next_q, next_d;

    // ---------------- key matching and edge detect ----------------
    logic enter_m, p_m, esc_m;
    always_comb begin
        enter_m = 1'b0;
        p_m     = 1'b0;
        esc_m   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enter_m |= (keycodes[8*i +: 8] == 8'h28);
            p_m     |= (keycodes[8*i +: 8] == 8'h13);
            esc_m   |= (keycodes[8*i +: 8] == 8'h29);
        end
    end

    logic enter_e, p_e, esc_e;
    assign enter_e = enter_m & ~enter_q;
    assign p_e     = p_m & ~p_q;
    assign esc_e   = esc_m & ~esc_q;

    // ---------------- gravity divider ----------------
    // Computed in 32 bits and compared before subtracting, so a large
    // level never wraps the period around to a huge value.
    logic [31:0] sub_w, cur_div_w;
    logic        tick_hit;
    assign sub_w     = DIV_STEP * 32'(level_q);
    assign cur_div_w = (BASE_DIV >= MIN_DIV + sub_w) ? (BASE_DIV - sub_w) : MIN_DIV;
    // >= (not ==) so a period that shrinks under the count ticks and wraps.
    assign tick_hit  = 32'(div_ctr_q) >= (cur_div_w - 32'd1);

    // ---------------- 7-bag selection ----------------
    logic [6:0]  used_eff, pick_oh, used_set;
    logic [2:0]  start_idx, pick;
    logic        found;
    logic [3:0]  idx;
    logic [16:0] thr_sum;

    always_comb begin
        used_eff  = (state_q == S_START) ? 7'd0 : used_q;
        start_idx = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
        pick      = start_idx;
        found     = 1'b0;
        idx       = 4'd0;
        for (int k = 0; k < 7; k++) begin
            idx = {1'b0, start_idx} + 4'(k);
            if (idx >= 4'd7) idx = idx - 4'd7;
            if (!found && !used_eff[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        pick_oh  = 7'd1 << pick;
        used_set = used_eff | pick_oh;
    end

    assign thr_sum = {1'b0, thr_q} + 17'(LEVEL_PTS);

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && esc_e) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (enter_e) state_d = S_START;
                S_START: state_d = S_PLAY;
                S_PLAY:  if (game_over) state_d = S_OVER;
                         else if (p_e) state_d = S_PAUSE;
                S_PAUSE: if (p_e) state_d = S_PLAY;
                S_OVER:  if (enter_e) state_d = S_START;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        div_ctr_d = div_ctr_q;
        level_d   = level_q;
        thr_d     = thr_q;
        used_d    = used_q;
        next_d    = next_q;
        case (state_q)
            S_START: begin
                div_ctr_d = 16'd0;
                level_d   = 4'd0;
                thr_d     = 16'(LEVEL_PTS);
                used_d    = used_set;
                next_d    = pick;
            end
            S_PLAY: begin
                div_ctr_d = tick_hit ? 16'd0 : div_ctr_q + 16'd1;
                if (score >= thr_q && 32'(level_q) < MAX_LEVEL) begin
                    level_d = level_q + 4'd1;
                    thr_d   = thr_sum[16] ? 16'hFFFF : thr_sum[15:0];
                end
                // Bag update is independent of game_over on the same frame.
                if (piece_req) begin
                    next_d = pick;
                    used_d = (used_set == 7'h7F) ? 7'd0 : used_set;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge vsync or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            enter_q   <= 1'b0;
            p_q       <= 1'b0;
            esc_q     <= 1'b0;
            div_ctr_q <= 16'd0;
            level_q   <= 4'd0;
            thr_q     <= 16'(LEVEL_PTS);
            lfsr_q    <= 16'hACE1;
            used_q    <= 7'd0;
            next_q    <= 3'd0;
        end else begin
            state_q   <= state_d;
            enter_q   <= enter_m;
            p_q       <= p_m;
            esc_q     <= esc_m;
            div_ctr_q <= div_ctr_d;
            level_q   <= level_d;
            thr_q     <= thr_d;
            // Taps 16,14,13,11; maximal length so a non-zero seed never hits 0.
            lfsr_q    <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            used_q    <= used_d;
            next_q    <= next_d;
        end
    end

    // ---------------- outputs ----------------
    assign state        = state_q;
    assign core_reset   = (state_q == S_IDLE) || (state_q == S_START);
    assign keycodes_out = (state_q == S_PLAY) ? keycodes : 32'h0;
    assign grav_tick    = (state_q == S_PLAY) && tick_hit;
    assign level        = level_q;
    assign next_shape   = next_q;

endmodule
